// File: rtl/match_sequencer.sv
// match_sequencer: match-level controller for the fighting game.
// Walks the match through pre-round countdown, fight, pause, round-end
// intermission and match-over. Decides each round from KO or time-out,
// keeps the best-of-N score and gates player controls. Every output comes
// straight from a flop.
module match_sequencer #(
  parameter int unsigned INTERMISSION_S = 32'd3,
  parameter int unsigned WINS_TO_MATCH  = 32'd2,
  parameter int unsigned ROUNDS_MAX     = 32'd3,
  parameter int unsigned HEALTH_W       = 32'd7
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_sec_tick,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_round_done,
  input  logic [HEALTH_W-1:0] i_p1_health,
  input  logic [HEALTH_W-1:0] i_p2_health,
  output logic                o_timer_start,
  output logic                o_timer_pause,
  output logic                o_health_reset,
  output logic                o_inputs_en,
  output logic [2:0]          o_state,
  output logic [1:0]          o_round_num,
  output logic [1:0]          o_p1_wins,
  output logic [1:0]          o_p2_wins,
  output logic [1:0]          o_winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_PAUSED     = 3'd3,
    S_ROUND_END  = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  // Round verdict / winner encoding, shared with o_winner.
  localparam logic [1:0] V_NONE = 2'b00;
  localparam logic [1:0] V_P1   = 2'b01;
  localparam logic [1:0] V_P2   = 2'b10;
  localparam logic [1:0] V_DRAW = 2'b11;

  // The tick that makes the count reach INTERMISSION_S ends the wait, so
  // the comparison is made against the last value before the target.
  localparam logic [3:0] L_SEC_TARGET = 4'(INTERMISSION_S);
  localparam logic [3:0] L_SEC_LAST   = L_SEC_TARGET - 4'd1;
  localparam logic [1:0] L_WINS       = 2'(WINS_TO_MATCH);
  localparam logic [1:0] L_RMAX       = 2'(ROUNDS_MAX);

  // Round decision in priority order: double KO, single KO, time-out.
  function automatic logic [1:0] f_round_verdict(
    input logic [HEALTH_W-1:0] p1,
    input logic [HEALTH_W-1:0] p2,
    input logic                done
  );
    logic       p1_ko;
    logic       p2_ko;
    logic [1:0] v;
    p1_ko = (p1 == {HEALTH_W{1'b0}});
    p2_ko = (p2 == {HEALTH_W{1'b0}});
    if (p1_ko && p2_ko) begin
      v = V_DRAW;
    end else if (p1_ko) begin
      v = V_P2;
    end else if (p2_ko) begin
      v = V_P1;
    end else if (done) begin
      if (p1 > p2) begin
        v = V_P1;
      end else if (p2 > p1) begin
        v = V_P2;
      end else begin
        v = V_DRAW;
      end
    end else begin
      v = V_NONE;
    end
    return v;
  endfunction

  // Match winner from the final score; a level score is a draw.
  function automatic logic [1:0] f_match_winner(
    input logic [1:0] p1w,
    input logic [1:0] p2w
  );
    logic [1:0] v;
    if (p1w > p2w) begin
      v = V_P1;
    end else if (p2w > p1w) begin
      v = V_P2;
    end else begin
      v = V_DRAW;
    end
    return v;
  endfunction

  // Win counters stop at 3 rather than wrapping.
  function automatic logic [1:0] f_sat_inc(input logic [1:0] w);
    logic [1:0] v;
    if (w == 2'd3) begin
      v = w;
    end else begin
      v = w + 2'd1;
    end
    return v;
  endfunction

  state_t     r_state;
  state_t     w_next;

  logic       r_start_d;
  logic       r_start_prev;
  logic       r_pause_d;
  logic       r_pause_prev;
  logic       w_start_edge;
  logic       w_pause_edge;

  logic [3:0] r_sec_cnt;
  logic       r_entry;
  logic       w_count_en;
  logic       w_tick_valid;
  logic       w_count_done;

  logic [1:0] r_p1_wins;
  logic [1:0] r_p2_wins;
  logic [1:0] r_round;
  logic [1:0] r_winner;
  logic [1:0] w_verdict;
  logic       w_match_decided;

  logic       w_match_clr;
  logic       w_round_adv;
  logic       w_set_winner;
  logic       w_fight_go;

  logic       r_timer_start;
  logic       r_timer_pause;
  logic       r_health_reset;
  logic       r_inputs_en;

  // Button edges come from the registered copy, so a press acts one cycle
  // after it is registered; both histories reset high to ignore held buttons.
  assign w_start_edge = r_start_d & ~r_start_prev;
  assign w_pause_edge = r_pause_d & ~r_pause_prev;

  // Seconds are counted only while waiting, and never in the entry cycle.
  assign w_count_en   = (r_state == S_COUNTDOWN) || (r_state == S_ROUND_END);
  assign w_tick_valid = i_sec_tick & ~r_entry;
  assign w_count_done = w_count_en && w_tick_valid && (r_sec_cnt == L_SEC_LAST);

  // KO and time-out only matter in FIGHT; PAUSED freezes the round.
  assign w_verdict = (r_state == S_FIGHT) ?
                     f_round_verdict(i_p1_health, i_p2_health, i_round_done) : V_NONE;

  assign w_match_decided = (r_p1_wins >= L_WINS) || (r_p2_wins >= L_WINS) ||
                           (r_round == L_RMAX);

  // Next-state and one-shot action decode.
  always_comb begin
    w_next       = r_state;
    w_match_clr  = 1'b0;
    w_round_adv  = 1'b0;
    w_set_winner = 1'b0;
    w_fight_go   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next      = S_COUNTDOWN;
          w_match_clr = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_COUNTDOWN: begin
        if (w_count_done) begin
          w_next     = S_FIGHT;
          w_fight_go = 1'b1;
        end else begin
          w_next = S_COUNTDOWN;
        end
      end
      S_FIGHT: begin
        if (w_verdict != V_NONE) begin
          w_next = S_ROUND_END;
        end else if (w_pause_edge) begin
          w_next = S_PAUSED;
        end else begin
          w_next = S_FIGHT;
        end
      end
      S_PAUSED: begin
        if (w_pause_edge) begin
          w_next = S_FIGHT;
        end else begin
          w_next = S_PAUSED;
        end
      end
      S_ROUND_END: begin
        if (w_count_done) begin
          if (w_match_decided) begin
            w_next       = S_MATCH_OVER;
            w_set_winner = 1'b1;
          end else begin
            w_next      = S_COUNTDOWN;
            w_round_adv = 1'b1;
          end
        end else begin
          w_next = S_ROUND_END;
        end
      end
      S_MATCH_OVER: begin
        if (w_start_edge) begin
          w_next      = S_COUNTDOWN;
          w_match_clr = 1'b1;
        end else begin
          w_next = S_MATCH_OVER;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Button history for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_start_d    <= 1'b1;
      r_start_prev <= 1'b1;
      r_pause_d    <= 1'b1;
      r_pause_prev <= 1'b1;
    end else begin
      r_start_d    <= i_start;
      r_start_prev <= r_start_d;
      r_pause_d    <= i_pause;
      r_pause_prev <= r_pause_d;
    end
  end

  // Second counter: cleared on every state change, flags the entry cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sec_cnt <= 4'd0;
      r_entry   <= 1'b1;
    end else if (w_next != r_state) begin
      r_sec_cnt <= 4'd0;
      r_entry   <= 1'b1;
    end else begin
      r_entry <= 1'b0;
      if (w_count_en && w_tick_valid) begin
        r_sec_cnt <= r_sec_cnt + 4'd1;
      end
    end
  end

  // Score, round number and match winner.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p1_wins <= 2'd0;
      r_p2_wins <= 2'd0;
      r_round   <= 2'd0;
      r_winner  <= V_NONE;
    end else if (w_match_clr) begin
      r_p1_wins <= 2'd0;
      r_p2_wins <= 2'd0;
      r_round   <= 2'd1;
      r_winner  <= V_NONE;
    end else begin
      if (w_verdict == V_P1) begin
        r_p1_wins <= f_sat_inc(r_p1_wins);
      end
      if (w_verdict == V_P2) begin
        r_p2_wins <= f_sat_inc(r_p2_wins);
      end
      if (w_round_adv) begin
        r_round <= r_round + 2'd1;
      end
      if (w_set_winner) begin
        r_winner <= f_match_winner(r_p1_wins, r_p2_wins);
      end
    end
  end

  // Pulse and level outputs, aligned with the state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timer_start  <= 1'b0;
      r_timer_pause  <= 1'b0;
      r_health_reset <= 1'b0;
      r_inputs_en    <= 1'b0;
    end else begin
      r_timer_start  <= w_fight_go;
      r_timer_pause  <= (w_next == S_PAUSED);
      r_health_reset <= w_match_clr | w_round_adv;
      r_inputs_en    <= (w_next == S_FIGHT);
    end
  end

  assign o_timer_start  = r_timer_start;
  assign o_timer_pause  = r_timer_pause;
  assign o_health_reset = r_health_reset;
  assign o_inputs_en    = r_inputs_en;
  assign o_state        = r_state;
  assign o_round_num    = r_round;
  assign o_p1_wins      = r_p1_wins;
  assign o_p2_wins      = r_p2_wins;
  assign o_winner       = r_winner;

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed test-plan scenarios followed by randomized
// stimulus, all checked every cycle against a behavioural match model.
module tb_match_sequencer;

  localparam int INTER = 3;
  localparam int WINS  = 2;
  localparam int RMAX  = 3;
  localparam int HW    = 7;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_sec_tick;
  logic          i_start;
  logic          i_pause;
  logic          i_round_done;
  logic [HW-1:0] i_p1_health;
  logic [HW-1:0] i_p2_health;
  logic          o_timer_start;
  logic          o_timer_pause;
  logic          o_health_reset;
  logic          o_inputs_en;
  logic [2:0]    o_state;
  logic [1:0]    o_round_num;
  logic [1:0]    o_p1_wins;
  logic [1:0]    o_p2_wins;
  logic [1:0]    o_winner;

  int n_checks = 0;
  int n_fail   = 0;

  match_sequencer #(
    .INTERMISSION_S(INTER),
    .WINS_TO_MATCH (WINS),
    .ROUNDS_MAX    (RMAX),
    .HEALTH_W      (HW)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_sec_tick    (i_sec_tick),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_round_done  (i_round_done),
    .i_p1_health   (i_p1_health),
    .i_p2_health   (i_p2_health),
    .o_timer_start (o_timer_start),
    .o_timer_pause (o_timer_pause),
    .o_health_reset(o_health_reset),
    .o_inputs_en   (o_inputs_en),
    .o_state       (o_state),
    .o_round_num   (o_round_num),
    .o_p1_wins     (o_p1_wins),
    .o_p2_wins     (o_p2_wins),
    .o_winner      (o_winner)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 countdown, 2 fight, 3 paused, 4 round end, 5 match over.
  int m_state = 0, m_round = 0, m_p1w = 0, m_p2w = 0, m_winner = 0;
  int m_ticks = 0, m_age = 0;
  bit m_ts = 0, m_hr = 0;
  // Last two sampled button levels (h1 = previous edge, h2 = the one before).
  bit st_h1 = 1, st_h2 = 1, pa_h1 = 1, pa_h2 = 1;

  task automatic model_reset();
    m_state = 0; m_round = 0; m_p1w = 0; m_p2w = 0; m_winner = 0;
    m_ticks = 0; m_age = 0; m_ts = 0; m_hr = 0;
    st_h1 = 1; st_h2 = 1; pa_h1 = 1; pa_h2 = 1;
  endtask

  task automatic model_step();
    bit start_e, pause_e, tick_ok;
    int nxt, v, p1h, p2h;
    start_e = st_h1 && !st_h2;
    pause_e = pa_h1 && !pa_h2;
    tick_ok = (i_sec_tick === 1'b1) && (m_age > 0);
    p1h = int'(i_p1_health);
    p2h = int'(i_p2_health);
    nxt = m_state; m_ts = 0; m_hr = 0; v = 0;
    case (m_state)
      0, 5: if (start_e) begin
        m_p1w = 0; m_p2w = 0; m_round = 1; m_winner = 0; m_hr = 1; nxt = 1;
      end
      1: if (tick_ok) begin
        m_ticks++;
        if (m_ticks == INTER) begin nxt = 2; m_ts = 1; end
      end
      2: begin
        if (p1h == 0 && p2h == 0) v = 3;
        else if (p1h == 0) v = 2;
        else if (p2h == 0) v = 1;
        else if (i_round_done === 1'b1) v = (p1h > p2h) ? 1 : ((p2h > p1h) ? 2 : 3);
        if (v != 0) begin
          nxt = 4;
          if (v == 1 && m_p1w < 3) m_p1w++;
          if (v == 2 && m_p2w < 3) m_p2w++;
        end else if (pause_e) nxt = 3;
      end
      3: if (pause_e) nxt = 2;
      4: if (tick_ok) begin
        m_ticks++;
        if (m_ticks == INTER) begin
          if (m_p1w >= WINS || m_p2w >= WINS || m_round == RMAX) begin
            nxt = 5;
            m_winner = (m_p1w > m_p2w) ? 1 : ((m_p2w > m_p1w) ? 2 : 3);
          end else begin
            m_round++; m_hr = 1; nxt = 1;
          end
        end
      end
      default: nxt = 0;
    endcase
    if (nxt != m_state) begin m_ticks = 0; m_age = 0; end
    else m_age++;
    m_state = nxt;
    st_h2 = st_h1; st_h1 = i_start;
    pa_h2 = pa_h1; pa_h1 = i_pause;
  endtask

  // Model advances on the same edges as the design, and resets asynchronously.
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    check("state",        o_state,        m_state);
    check("round_num",    o_round_num,    m_round);
    check("p1_wins",      o_p1_wins,      m_p1w);
    check("p2_wins",      o_p2_wins,      m_p2w);
    check("winner",       o_winner,       m_winner);
    check("timer_start",  o_timer_start,  int'(m_ts));
    check("health_reset", o_health_reset, int'(m_hr));
    check("inputs_en",    o_inputs_en,    int'(m_state == 2));
    check("timer_pause",  o_timer_pause,  int'(m_state == 3));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      i_sec_tick = 1'b1; @(negedge i_clk);
      i_sec_tick = 1'b0; @(negedge i_clk);
    end
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int k;
    k = 0;
    while (o_state !== 3'(code) && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check(name, o_state, code);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1; i_start = 1'b1; i_pause = 1'b0; i_sec_tick = 1'b0;
    i_round_done = 1'b0; i_p1_health = 7'd100; i_p2_health = 7'd100;
    step(3);
    check("rst_state", o_state, 0);
    check("rst_round", o_round_num, 0);

    // Start held through reset gives no edge.
    i_reset = 1'b0;
    step(4);
    check("held_start_idle", o_state, 0);
    i_start = 1'b0; step(2); i_start = 1'b1;
    wait_state(1, 6, "enter_countdown");
    check("first_health_reset", o_health_reset, 1);
    check("round_one", o_round_num, 1);
    i_start = 1'b0;

    // Two ticks are not enough, the third starts the fight.
    step(1); tick_n(2);
    check("cd_two_ticks", o_state, 1);
    tick_n(1);
    check("cd_to_fight", o_state, 2);

    // P2 KO; a tick in the round-end entry cycle does not count.
    i_p2_health = 7'd0; step(1);
    check("ko_round_end", o_state, 4);
    check("ko_p1_win1", o_p1_wins, 1);
    i_p2_health = 7'd100; i_sec_tick = 1'b1; step(1); i_sec_tick = 1'b0;
    tick_n(2);
    check("re_entry_tick_ignored", o_state, 4);
    tick_n(1);
    check("re_to_countdown", o_state, 1);
    check("round_two", o_round_num, 2);
    step(1); tick_n(3);
    i_p2_health = 7'd0; step(1); i_p2_health = 7'd100;
    check("ko_p1_win2", o_p1_wins, 2);
    step(1); tick_n(3);
    check("match_over1", o_state, 5);
    check("winner_p1", o_winner, 1);
    check("final_round2", o_round_num, 2);

    // Three time-out draws run to the round limit.
    i_start = 1'b1;
    wait_state(1, 6, "restart1");
    i_start = 1'b0;
    check("restart_winner_clr", o_winner, 0);
    for (int r = 0; r < 3; r++) begin
      step(1); tick_n(3);
      i_p1_health = 7'd40; i_p2_health = 7'd40; i_round_done = 1'b1;
      step(1); i_round_done = 1'b0;
      check("draw_round_end", o_state, 4);
      check("draw_no_win", o_p1_wins + o_p2_wins, 0);
      i_p1_health = 7'd100; i_p2_health = 7'd100;
      step(1); tick_n(3);
    end
    check("draw_match_over", o_state, 5);
    check("draw_winner", o_winner, 3);
    check("draw_round3", o_round_num, 3);

    // Pause freezes KO and time-out; resume has no timer start pulse.
    i_start = 1'b1;
    wait_state(1, 6, "restart2");
    i_start = 1'b0;
    step(1); tick_n(3);
    i_pause = 1'b1;
    wait_state(3, 5, "to_paused");
    check("paused_timer_pause", o_timer_pause, 1);
    check("paused_inputs_off", o_inputs_en, 0);
    i_p1_health = 7'd0; i_round_done = 1'b1; step(1); i_round_done = 1'b0;
    step(2);
    check("paused_ko_ignored", o_state, 3);
    i_pause = 1'b0; step(2); i_pause = 1'b1;
    wait_state(2, 5, "resume_fight");
    check("resume_no_timer_start", o_timer_start, 0);
    step(1);
    check("resume_ko", o_state, 4);
    check("resume_p2_win", o_p2_wins, 1);
    i_p1_health = 7'd100; i_pause = 1'b0;

    // Start ignored in FIGHT; double KO + time-out + pause edge is a draw.
    step(1); tick_n(3); step(1); tick_n(3);
    check("fight_round2", o_state, 2);
    i_start = 1'b1; step(4);
    check("start_ignored_fight", o_state, 2);
    i_start = 1'b0;
    i_pause = 1'b1; step(1);
    i_p1_health = 7'd0; i_p2_health = 7'd0; i_round_done = 1'b1;
    step(1); i_round_done = 1'b0;
    check("simul_round_end", o_state, 4);
    check("simul_p2_unchanged", o_p2_wins, 1);
    check("simul_p1_unchanged", o_p1_wins, 0);
    i_p1_health = 7'd100; i_p2_health = 7'd100; i_pause = 1'b0;

    // Asynchronous reset between clock edges.
    step(1);
    @(posedge i_clk); #2;
    i_reset = 1'b1; #1;
    check("async_rst_state", o_state, 0);
    check("async_rst_round", o_round_num, 0);
    check("async_rst_wins", o_p2_wins, 0);
    step(2); i_reset = 1'b0; step(1);

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk); #1;
      i_sec_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) i_start = ~i_start;
      if ($urandom_range(0, 11) == 0) i_pause = ~i_pause;
      i_round_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) begin
        i_p1_health = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        i_p2_health = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        if ($urandom_range(0, 3) == 0) i_p2_health = i_p1_health;
      end
      i_reset = ($urandom_range(0, 1499) == 0);
    end
    @(negedge i_clk); #1;
    i_reset = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
